// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch after boot and chooses the next PC.
// The next PC comes from a trap vector, an Execute redirect, a redirect deferred
// across a memory wait, or PC+4. It also drives the PC stall and Decode flush controls.
// Ports: CLK/RESET (sync, active-high); PC, HazardStallF, PCSrcE, PCTargetE, TrapReq,
//        TrapBase, IMemReady in; IMemReq, PC_IN, StallF, FlushD, TrapAck, EPC out.
//        All outputs except EPC are combinational; EPC is registered.
module fetch_controller #(
  parameter logic [31:0] PC_INIT     = 32'h00400000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        HazardStallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        TrapReq,
  input  logic [31:0] TrapBase,
  input  logic        IMemReady,
  output logic        IMemReq,
  output logic [31:0] PC_IN,
  output logic        StallF,
  output logic        FlushD,
  output logic        TrapAck,
  output logic [31:0] EPC
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, TRAP} state_t;

  localparam logic [3:0] BOOT_CNT = 4'(BOOT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        pend_vld;
  logic [31:0] pend_tgt;
  logic        trap_armed;
  logic [31:0] epc_q;

  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic [31:0] trap_tgt;
  logic        trap_ok;
  logic        trap_take;

  // Targets are word aligned by masking the low two bits.
  assign pc_plus4  = PC + 32'd4;
  assign redir_tgt = PCTargetE & 32'hFFFF_FFFC;
  assign trap_tgt  = TrapBase & 32'hFFFF_FFFC;
  assign trap_ok   = TrapReq && trap_armed;
  assign EPC       = epc_q;

  always_comb begin
    IMemReq   = 1'b0;
    StallF    = 1'b1;
    FlushD    = 1'b0;
    TrapAck   = 1'b0;
    PC_IN     = pc_plus4;
    trap_take = 1'b0;
    if (RESET) begin
      PC_IN = PC_INIT;
    end else begin
      case (state)
        BOOT: PC_IN = PC_INIT;
        FETCH, WAIT: begin
          IMemReq = 1'b1;
          if (!IMemReady) begin
            // Fetch not complete: hold PC; a redirect is accepted and deferred.
            StallF = 1'b1;
            FlushD = PCSrcE;
          end else if (trap_ok) begin
            // Hold PC so the TRAP cycle captures the trapped instruction's address.
            trap_take = 1'b1;
            StallF    = 1'b1;
            PC_IN     = PC;
          end else if (PCSrcE) begin
            // A live redirect wins over the hazard stall.
            StallF = 1'b0;
            FlushD = 1'b1;
            PC_IN  = redir_tgt;
          end else if (pend_vld) begin
            StallF = 1'b0;
            PC_IN  = pend_tgt;
          end else begin
            StallF = HazardStallF;
          end
        end
        TRAP: begin
          StallF  = 1'b0;
          FlushD  = 1'b1;
          TrapAck = 1'b1;
          PC_IN   = trap_tgt;
        end
        default: PC_IN = PC_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= BOOT;
      cnt        <= BOOT_CNT;
      pend_vld   <= 1'b0;
      pend_tgt   <= 32'h0;
      trap_armed <= 1'b1;
      epc_q      <= 32'h0;
    end else begin
      // Re-arm once TrapReq is seen low; the TRAP branch below overrides this.
      if (!TrapReq) trap_armed <= 1'b1;
      case (state)
        BOOT: begin
          if (cnt <= 4'd1) state <= FETCH;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        FETCH, WAIT: begin
          if (!IMemReady) begin
            state <= WAIT;
            if (PCSrcE) begin
              // A newer redirect overwrites an older pending one.
              pend_vld <= 1'b1;
              pend_tgt <= redir_tgt;
            end
          end else begin
            pend_vld <= 1'b0;
            state    <= trap_take ? TRAP : FETCH;
          end
        end
        TRAP: begin
          epc_q      <= PC;
          pend_vld   <= 1'b0;
          trap_armed <= 1'b0;
          state      <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed stimulus for fetch_controller with hand-computed expectations.
module tb_fetch_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic        HazardStallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        TrapReq;
  logic [31:0] TrapBase;
  logic        IMemReady;
  logic        IMemReq;
  logic [31:0] PC_IN;
  logic        StallF;
  logic        FlushD;
  logic        TrapAck;
  logic [31:0] EPC;

  int checks = 0;
  int errors = 0;

  fetch_controller dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .HazardStallF(HazardStallF),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .TrapReq(TrapReq), .TrapBase(TrapBase),
    .IMemReady(IMemReady), .IMemReq(IMemReq), .PC_IN(PC_IN), .StallF(StallF),
    .FlushD(FlushD), .TrapAck(TrapAck), .EPC(EPC)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; PC = 32'h00400000; HazardStallF = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; TrapReq = 1'b0; TrapBase = 32'h0; IMemReady = 1'b1;
    tick(); tick();
    // Reset values
    chk("rst_stall", 32'(StallF), 32'd1);
    chk("rst_req",   32'(IMemReq), 32'd0);
    chk("rst_flush", 32'(FlushD), 32'd0);
    chk("rst_ack",   32'(TrapAck), 32'd0);
    chk("rst_pcin",  PC_IN, 32'h00400000);
    chk("rst_epc",   EPC, 32'h0);

    // Boot: two stalled cycles, TrapReq ignored
    RESET = 1'b0; TrapReq = 1'b1; #1;
    chk("boot1_stall", 32'(StallF), 32'd1);
    chk("boot1_req",   32'(IMemReq), 32'd0);
    chk("boot1_ack",   32'(TrapAck), 32'd0);
    tick();
    chk("boot2_stall", 32'(StallF), 32'd1);
    chk("boot2_req",   32'(IMemReq), 32'd0);
    TrapReq = 1'b0;
    tick();
    chk("fetch0_req",   32'(IMemReq), 32'd1);
    chk("fetch0_stall", 32'(StallF), 32'd0);
    chk("fetch0_pcin",  PC_IN, 32'h00400004);

    // Taken branch with unaligned target
    PC = 32'h00400010; PCSrcE = 1'b1; PCTargetE = 32'h00400103; #1;
    chk("br_pcin",  PC_IN, 32'h00400100);
    chk("br_flush", 32'(FlushD), 32'd1);
    chk("br_stall", 32'(StallF), 32'd0);
    tick();

    // Redirect overrides hazard stall
    PC = 32'h00400100; HazardStallF = 1'b1; PCTargetE = 32'h00400300; #1;
    chk("hzbr_stall", 32'(StallF), 32'd0);
    chk("hzbr_pcin",  PC_IN, 32'h00400300);
    chk("hzbr_flush", 32'(FlushD), 32'd1);
    tick();
    PCSrcE = 1'b0; #1;
    chk("hz_stall", 32'(StallF), 32'd1);
    chk("hz_flush", 32'(FlushD), 32'd0);
    tick();

    // PC+4 wraparound
    HazardStallF = 1'b0; PC = 32'hFFFFFFFC; #1;
    chk("wrap_pcin",  PC_IN, 32'h00000000);
    chk("wrap_stall", 32'(StallF), 32'd0);
    tick();

    // Memory wait with redirect pulsed in the 2nd cycle
    PC = 32'h00400040; IMemReady = 1'b0; #1;
    chk("w1_stall", 32'(StallF), 32'd1);
    chk("w1_req",   32'(IMemReq), 32'd1);
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h00400200; #1;
    chk("w2_stall", 32'(StallF), 32'd1);
    chk("w2_flush", 32'(FlushD), 32'd1);
    tick();
    PCSrcE = 1'b0; #1;
    chk("w3_stall", 32'(StallF), 32'd1);
    chk("w3_flush", 32'(FlushD), 32'd0);
    chk("w3_req",   32'(IMemReq), 32'd1);
    tick();
    IMemReady = 1'b1; #1;
    chk("wx_stall", 32'(StallF), 32'd0);
    chk("wx_pcin",  PC_IN, 32'h00400200);
    tick();
    PC = 32'h00400200; #1;
    chk("wpost_pcin", PC_IN, 32'h00400204);
    tick();

    // Trap: accept cycle holds PC, then TRAP cycle
    PC = 32'h00400020; TrapBase = 32'h00000080; TrapReq = 1'b1; #1;
    chk("tacc_stall", 32'(StallF), 32'd1);
    chk("tacc_ack",   32'(TrapAck), 32'd0);
    tick();
    chk("trap_ack",   32'(TrapAck), 32'd1);
    chk("trap_pcin",  PC_IN, 32'h00000080);
    chk("trap_flush", 32'(FlushD), 32'd1);
    chk("trap_stall", 32'(StallF), 32'd0);
    tick();
    PC = 32'h00000080; #1;
    chk("tpost_epc",   EPC, 32'h00400020);
    chk("tpost_ack",   32'(TrapAck), 32'd0);
    chk("tpost_stall", 32'(StallF), 32'd0);
    chk("tpost_pcin",  PC_IN, 32'h00000084);
    tick();
    // Still high: no retrigger
    chk("tnoretrig_stall", 32'(StallF), 32'd0);
    TrapReq = 1'b0;
    tick();
    // Re-armed: second trap with unaligned vector
    TrapReq = 1'b1; PC = 32'h00000088; TrapBase = 32'h00000103; #1;
    chk("t2acc_stall", 32'(StallF), 32'd1);
    tick();
    chk("t2_ack",  32'(TrapAck), 32'd1);
    chk("t2_pcin", PC_IN, 32'h00000100);
    tick();
    chk("t2_epc", EPC, 32'h00000088);
    TrapReq = 1'b0;
    tick();

    // Reset mid-WAIT drops a pending redirect
    PC = 32'h00400040; IMemReady = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h00400500;
    tick();
    PCSrcE = 1'b0; RESET = 1'b1; #1;
    chk("rw_stall", 32'(StallF), 32'd1);
    chk("rw_req",   32'(IMemReq), 32'd0);
    chk("rw_pcin",  PC_IN, 32'h00400000);
    chk("rw_flush", 32'(FlushD), 32'd0);
    tick(); tick();
    RESET = 1'b0; IMemReady = 1'b1; PC = 32'h00400000;
    tick(); tick();
    chk("rw_pcin_after", PC_IN, 32'h00400004);
    chk("rw_epc_after",  EPC, 32'h0);
    chk("rw_req_after",  32'(IMemReq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00400000, meaning the boot fetch address.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, meaning the number of cycles fetch is held after reset release (range 1-15).
REQ-003 SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port PC, input, 32 bits: current fetch address from the program counter register.
REQ-006 SHALL have port HazardStallF, input, 1 bit: load-use stall request from the hazard unit.
REQ-007 SHALL have port PCSrcE, input, 1 bit: taken branch or jump resolved in Execute.
REQ-008 SHALL have port PCTargetE, input, 32 bits: redirect target from Execute.
REQ-009 SHALL have port TrapReq, input, 1 bit: trap or interrupt request, level-sensitive.
REQ-010 SHALL have port TrapBase, input, 32 bits: trap vector address.
REQ-011 SHALL have port IMemReady, input, 1 bit: instruction memory has returned data for the current request.
REQ-012 SHALL have port IMemReq, output, 1 bit: instruction fetch request valid.
REQ-013 SHALL have port PC_IN, output, 32 bits: next-PC value to the program counter.
REQ-014 SHALL have port StallF, output, 1 bit: hold the program counter.
REQ-015 SHALL have port FlushD, output, 1 bit: squash the Decode-stage instruction.
REQ-016 SHALL have port TrapAck, output, 1 bit: single-cycle pulse when a trap is taken.
REQ-017 SHALL have port EPC, output, 32 bits: registered address of the trapped instruction.

Function
REQ-018 SHALL implement the states BOOT, FETCH, WAIT and TRAP.
REQ-019 SHALL behave in BOOT as follows: StallF=1, IMemReq=0, down-counter loaded with BOOT_CYCLES; it SHALL move to FETCH when the counter reaches 0.
REQ-020 SHALL behave in FETCH as follows: IMemReq=1; if IMemReady=0, it SHALL assert StallF=1 and move to WAIT.
REQ-021 SHALL behave in WAIT as follows: IMemReq=1 and StallF=1 until IMemReady=1, then return to FETCH with a PC update that same cycle.
REQ-022 SHALL select PC_IN by priority: TRAP, then PCSrcE, then pending redirect, then PC+4.
REQ-023 SHALL compute PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-024 SHALL force PC_IN[1:0] to 2'b00 for all redirect and trap targets.
REQ-025 SHALL assert StallF in FETCH when HazardStallF=1 and PCSrcE=0; when PCSrcE=1, the redirect SHALL override the hazard stall (StallF=0, FlushD=1).
REQ-026 SHALL assert FlushD=1 in the cycle PCSrcE=1 is accepted and in the cycle a trap is taken.
REQ-027 SHALL latch PCTargetE into a pending-redirect register and set a pending flag when PCSrcE=1 arrives in WAIT; the pending target SHALL drive PC_IN on the IMemReady cycle, after which the flag clears.
REQ-028 SHALL overwrite the pending target with the newer PCTargetE when a second PCSrcE arrives while a redirect is pending.
REQ-029 SHALL accept TrapReq=1 only in FETCH with IMemReady=1, or on the WAIT exit cycle; when accepted it SHALL enter TRAP for one cycle.
REQ-030 SHALL behave in TRAP as follows: EPC<=PC, PC_IN=TrapBase, StallF=0, FlushD=1, TrapAck=1, any pending redirect discarded; next state FETCH.
REQ-031 SHALL ignore TrapReq while in BOOT; a trap SHALL NOT retrigger until TrapReq has been sampled low for at least one cycle after TrapAck.
REQ-032 SHALL generate all outputs except EPC combinationally from state and inputs; EPC SHALL be registered.

Reset
REQ-033 SHALL, on RESET=1 at a rising edge, set state=BOOT, counter=BOOT_CYCLES, EPC=32'h0, pending flag=0 and trap re-arm=1.
REQ-034 SHALL, while RESET=1, drive StallF=1, IMemReq=0, FlushD=0, TrapAck=0 and PC_IN=PC_INIT.
REQ-035 SHALL, on RESET asserted mid-WAIT or mid-TRAP, abandon the state and lose any pending redirect.

Verification
REQ-036 SHALL cover: reset release with BOOT_CYCLES=2 -> StallF=1 for 2 cycles, then IMemReq=1 and PC_IN=32'h00400004.
REQ-037 SHALL cover: PC=32'h00400010, PCSrcE=1, PCTargetE=32'h00400103 -> PC_IN=32'h00400100, FlushD=1.
REQ-038 SHALL cover: IMemReady=0 for 3 cycles with PCSrcE pulsed (target 32'h00400200) in the 2nd -> StallF=1 for 3 cycles, then PC_IN=32'h00400200.
REQ-039 SHALL cover: TrapReq=1 at PC=32'h00400020 with TrapBase=32'h00000080 -> TrapAck pulse, EPC=32'h00400020, PC_IN=32'h00000080, FlushD=1.
REQ-040 SHALL cover: HazardStallF=1 and PCSrcE=1 in the same cycle -> StallF=0, PC_IN=target, FlushD=1.
REQ-041 SHALL cover: PC=32'hFFFFFFFC sequential fetch -> PC_IN=32'h00000000.
